// File: rtl/alu_dmem_mux.sv
// Datapath slice: combinational 8-function ALU, 256x16 single-port data memory
// with registered read, and the result mux that feeds the register-file write port.
module alu_dmem_mux (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [2:0]  alu_sel,
  input  logic [7:0]  d_addr,
  input  logic        d_wr,
  input  logic        rf_s,
  output logic [15:0] alu_out,
  output logic [15:0] dmem_out,
  output logic [15:0] mux_out
);

  localparam logic [2:0] OP_ZERO = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_PASS = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;
  localparam logic [2:0] OP_AND  = 3'd6;
  localparam logic [2:0] OP_INC  = 3'd7;

  // Power-up image carried by the RAM bitstream; reset never touches it.
  logic [15:0] mem [0:255] = '{
    27:      16'h21BA,
    42:      16'hA04E,
    60:      16'h71AC,
    126:     16'hB17F,
    default: 16'h0000
  };

  always_comb begin
    alu_out = 16'h0000;
    case (alu_sel)
      OP_ZERO: alu_out = 16'h0000;
      OP_ADD:  alu_out = a + b;
      OP_SUB:  alu_out = a - b;
      OP_PASS: alu_out = a;
      OP_XOR:  alu_out = a ^ b;
      OP_OR:   alu_out = a | b;
      OP_AND:  alu_out = a & b;
      OP_INC:  alu_out = a + 16'd1;
      default: alu_out = 16'h0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset && d_wr) begin
      mem[d_addr] <= a;
    end
  end

  // Read-before-write: the nonblocking write above lands after this read samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      dmem_out <= 16'h0000;
    end else begin
      dmem_out <= mem[d_addr];
    end
  end

  assign mux_out = rf_s ? dmem_out : alu_out;

endmodule

// File: tb/tb_alu_dmem_mux.sv
// Directed self-checking bench for alu_dmem_mux: memory image, write/readback,
// read-during-write, ALU sweep and wrap cases, and reset behaviour.
module tb_alu_dmem_mux;

  logic        clk;
  logic        reset;
  logic [15:0] a;
  logic [15:0] b;
  logic [2:0]  alu_sel;
  logic [7:0]  d_addr;
  logic        d_wr;
  logic        rf_s;
  logic [15:0] alu_out;
  logic [15:0] dmem_out;
  logic [15:0] mux_out;

  int errors = 0;
  int checks = 0;

  alu_dmem_mux dut (
    .clk      (clk),
    .reset    (reset),
    .a        (a),
    .b        (b),
    .alu_sel  (alu_sel),
    .d_addr   (d_addr),
    .d_wr     (d_wr),
    .rf_s     (rf_s),
    .alu_out  (alu_out),
    .dmem_out (dmem_out),
    .mux_out  (mux_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
    $display("check %-14s observed=%h expected=%h", tag, observed, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] sweep_exp [8];

  initial begin
    sweep_exp = '{16'h0000, 16'h0FFF, 16'hF1E1, 16'h00F0,
                  16'h0FFF, 16'h0FFF, 16'h0000, 16'h00F1};
    reset = 1'b1; a = 16'h0000; b = 16'h0000; alu_sel = 3'd0;
    d_addr = 8'd0; d_wr = 1'b0; rf_s = 1'b1;

    // Reset clears the read register; mux follows it.
    tick();
    check("rst_dmem", dmem_out, 16'h0000);
    check("rst_mux", mux_out, 16'h0000);

    // Initial image reads, one-cycle latency.
    reset = 1'b0; d_addr = 8'd27;
    tick();
    check("init27_dmem", dmem_out, 16'h21BA);
    check("init27_mux", mux_out, 16'h21BA);
    d_addr = 8'd126;
    tick();
    check("init126", dmem_out, 16'hB17F);
    d_addr = 8'd0;
    tick();
    check("init0", dmem_out, 16'h0000);

    // Write then readback; neighbour untouched.
    a = 16'h1234; d_addr = 8'h10; d_wr = 1'b1;
    tick();
    d_wr = 1'b0;
    tick();
    check("wr_readback", dmem_out, 16'h1234);
    d_addr = 8'd42;
    tick();
    check("init42", dmem_out, 16'hA04E);

    // ALU sweep through the mux.
    rf_s = 1'b0; a = 16'h00F0; b = 16'h0F0F;
    for (int i = 0; i < 8; i++) begin
      alu_sel = 3'(i);
      #1;
      check($sformatf("sweep%0d_alu", i), alu_out, sweep_exp[i]);
      check($sformatf("sweep%0d_mux", i), mux_out, sweep_exp[i]);
    end

    // Wrap-around cases.
    a = 16'hFFFF; b = 16'h0001; alu_sel = 3'd1;
    #1; check("wrap_add", alu_out, 16'h0000);
    alu_sel = 3'd7;
    #1; check("wrap_inc", alu_out, 16'h0000);
    a = 16'h0000; alu_sel = 3'd2;
    #1; check("wrap_sub", alu_out, 16'hFFFF);

    // Read-during-write returns the old word.
    rf_s = 1'b1; a = 16'hBEEF; d_addr = 8'd60; d_wr = 1'b1;
    tick();
    check("rdw_old", dmem_out, 16'h71AC);
    d_wr = 1'b0;
    tick();
    check("rdw_new", dmem_out, 16'hBEEF);

    // Reset mid-operation blocks the write and leaves the ALU alone.
    reset = 1'b1; d_wr = 1'b1; d_addr = 8'd27; a = 16'h5555; alu_sel = 3'd3;
    tick();
    check("midrst_dmem", dmem_out, 16'h0000);
    check("midrst_mux", mux_out, 16'h0000);
    check("midrst_alu", alu_out, 16'h5555);
    reset = 1'b0; d_wr = 1'b0;
    tick();
    check("midrst_nowr", dmem_out, 16'h21BA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_dmem_mux.md
ALU_DMEM_MUX -- requirements
Module: alu_dmem_mux

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; all state changes on the rising edge of clk.
REQ-002 clk  input  1  sole clock; all registers update on its rising edge.
REQ-003 reset  input  1  synchronous active-high reset; sampled only on the rising edge of clk.
REQ-004 a  input  16  ALU operand A; also the data-memory write data.
REQ-005 b  input  16  ALU operand B.
REQ-006 alu_sel  input  3  ALU operation select.
REQ-007 d_addr  input  8  data-memory address (256 words).
REQ-008 d_wr  input  1  data-memory write enable.
REQ-009 rf_s  input  1  result mux select: 0 = ALU, 1 = memory.
REQ-010 alu_out  output  16  combinational ALU result.
REQ-011 dmem_out  output  16  registered data-memory read data.
REQ-012 mux_out  output  16  selected result, intended for the register-file write port.

Function
REQ-013 alu_out SHALL be purely combinational from a, b and alu_sel, with no clock or reset dependence.
REQ-014 alu_sel 0 SHALL produce 0x0000.
REQ-015 alu_sel 1 SHALL produce a+b and alu_sel 2 SHALL produce a-b, both modulo 2^16 with carry and borrow discarded.
REQ-016 alu_sel 3 SHALL produce a (pass-through).
REQ-017 alu_sel 4 SHALL produce a^b, alu_sel 5 SHALL produce a|b, and alu_sel 6 SHALL produce a&b.
REQ-018 alu_sel 7 SHALL produce a+1 modulo 2^16, so 0xFFFF wraps to 0x0000.
REQ-019 Data memory SHALL be 256 x 16-bit with one port, where d_addr indexes words 0..255 and there is no out-of-range case.
REQ-020 Read latency SHALL be one cycle: at each rising edge without reset, dmem_out <= mem[d_addr] as sampled at that edge.
REQ-021 Write: at a rising edge with d_wr=1 and reset=0, mem[d_addr] <= a.
REQ-022 Read-during-write to the same address SHALL return the old word on dmem_out; the new word is visible from the next read.
REQ-023 mux_out SHALL equal alu_out when rf_s=0 and dmem_out when rf_s=1, combinationally, with no added latency.
REQ-024 Memory SHALL power up with 0x0000 in all words except mem[27]=0x21BA (8634), mem[42]=0xA04E (41038), mem[60]=0x71AC (29100) and mem[126]=0xB17F (45439).

Reset
REQ-025 A rising edge with reset=1 SHALL clear dmem_out to 0x0000.
REQ-026 A rising edge with reset=1 SHALL suppress any write even if d_wr=1.
REQ-027 Reset SHALL NOT alter memory contents, which retain initial or previously written values.
REQ-028 Reset SHALL NOT affect alu_out.
REQ-029 mux_out SHALL follow REQ-023 during reset, so it is 0x0000 when rf_s=1.
REQ-030 The first read after reset deasserts SHALL return valid data one cycle later, per REQ-020.

Verification
REQ-031 Initial-content read: reset one cycle, then d_addr=27, rf_s=1, d_wr=0 -> after one edge, dmem_out=mux_out=0x21BA; d_addr=126 -> next edge 0xB17F; d_addr=0 -> next edge 0x0000.
REQ-032 Write then readback: a=0x1234, d_addr=0x10, d_wr=1 for one edge; then d_wr=0 -> next edge dmem_out=0x1234; mem[42] still reads 0xA04E.
REQ-033 ALU sweep with a=0x00F0, b=0x0F0F, rf_s=0, stepping alu_sel 0..7 -> alu_out and mux_out are 0x0000, 0x0FFF, 0xF1E1, 0x00F0, 0x0FFF, 0x0FFF, 0x0000, 0x00F1.
REQ-034 Wrap cases: a=0xFFFF, b=0x0001 -> alu_sel 1 gives 0x0000, alu_sel 7 gives 0x0000; a=0x0000, b=0x0001 with alu_sel 2 gives 0xFFFF.
REQ-035 Read-during-write: mem[60]=0x71AC, then a=0xBEEF, d_addr=60, d_wr=1 -> after that edge dmem_out=0x71AC; after the next edge with d_wr=0, dmem_out=0xBEEF.
REQ-036 Reset mid-operation: reset=1 with d_wr=1, d_addr=27, a=0x5555 -> dmem_out=0x0000 and no write; then reset=0, d_wr=0 -> next edge dmem_out=0x21BA.
